uart_rx: RTL and testbench

// - Receive half of the 16550-compatible UART. Takes serial rx_i, oversamples it at 16x baud
//   and assembles characters of 5-8 bits with optional parity.
// - Pushes each character into a 16-entry RX FIFO; RBR reads pop that FIFO.
// - Produces the LSR receive status bits (DR, OE, PE, FE, BI) and the received-data interrupt.
// - Sits beside the TX path inside UARTmodule and uses the same DLL/DLM divisor and LCR.

---
 rtl/uart_pkg.sv | 62 ++++++
 rtl/uart_rx_if.sv | 45 ++++
 rtl/uart_fifo.sv | 76 +++++++
 rtl/uart_rx.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_uart_rx.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART receive/transmit
//               paths: receiver state encoding, FCR trigger levels, LCR field
//               positions, default FIFO depth and parity/trigger helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package uart_pkg;

    localparam int FIFO_DEPTH_DEF = 16;

    // FCR[7:6] trigger levels, in FIFO entries
    localparam int TRIG_1  = 1;
    localparam int TRIG_4  = 4;
    localparam int TRIG_8  = 8;
    localparam int TRIG_14 = 14;

    // LCR field positions
    localparam int LCR_WLS   = 0;   // [1:0] word length select, 5 + value bits
    localparam int LCR_PEN   = 3;
    localparam int LCR_EPS   = 4;
    localparam int LCR_STICK = 5;

    typedef enum logic [2:0] {
        RX_IDLE     = 3'd0,
        RX_START    = 3'd1,
        RX_DATA     = 3'd2,
        RX_PARITY   = 3'd3,
        RX_STOP     = 3'd4,
        RX_BRK_WAIT = 3'd5
    } rx_state_e;

    // Trigger level in entries for an FCR[7:6] code
    function automatic logic [4:0] trig_level(input logic [1:0] sel);
        case (sel)
            2'b00:   return 5'(TRIG_1);
            2'b01:   return 5'(TRIG_4);
            2'b10:   return 5'(TRIG_8);
            default: return 5'(TRIG_14);
        endcase
    endfunction

    // Expected parity bit. Bits above the word length must already be zero.
    // Stick parity forces the bit to ~EPS; otherwise EPS selects even parity.
    function automatic logic exp_parity(input logic [7:0] data,
                                        input logic       eps,
                                        input logic       stick);
        if (stick)
            return ~eps;
        else if (eps)
            return ^data;
        else
            return ~(^data);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_if.sv
// ============================================================================
// Module      : uart_rx_if
// Description : Host-side register interface of the UART receiver: RBR pop
//               and LSR read strobes from the host; FIFO head, LSR receive
//               status, FIFO fill level and receive interrupt from the UART.
// Modports    : master - host / register block (drives the strobes)
//               slave  - receiver (drives data, status and interrupt)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          fifo_pop_i;
    logic          lsr_rd_i;
    logic [7:0]    rdata_o;
    logic          data_ready_o;
    logic          overrun_o;
    logic          parity_err_o;
    logic          framing_err_o;
    logic          break_o;
    logic [CW-1:0] fifo_count_o;
    logic          irq_rx_o;

    modport master (
        output fifo_pop_i, lsr_rd_i,
        input  rdata_o, data_ready_o, overrun_o, parity_err_o,
               framing_err_o, break_o, fifo_count_o, irq_rx_o
    );

    modport slave (
        input  fifo_pop_i, lsr_rd_i,
        output rdata_o, data_ready_o, overrun_o, parity_err_o,
               framing_err_o, break_o, fifo_count_o, irq_rx_o
    );

endinterface

`default_nettype wire

// File: rtl/uart_fifo.sv
// ============================================================================
// Module      : uart_fifo
// Description : Synchronous show-ahead FIFO with occupancy count. A push while
//               full is accepted only when a pop happens in the same cycle; a
//               pop while empty is ignored. The head reads as zero when empty.
// Ports       : clk, rst (async, active-low), i_clr (flush), i_push/i_wdata,
//               i_pop, o_rdata (head), o_count, o_full, o_empty
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_fifo #(
    parameter int DEPTH = 16,       // power of two, >= 2
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & (~o_full | i_pop);
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_count   = r_count;
    assign o_rdata   = o_empty ? '0 : r_mem[r_rptr];

    // Pointers wrap naturally modulo DEPTH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clr)
            r_mem[r_wptr] <= i_wdata;
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : 16550-compatible UART receiver. Synchronises rx_i, samples it
//               on a 16x baud tick, assembles 5-8 bit characters with optional
//               parity, pushes them into an RX FIFO and maintains the LSR
//               receive status bits and the receive-data interrupt.
// Ports       : clk, rst (async, active-low), rx_i (serial in, idle 1),
//               baud_div_i {DLM,DLL}, lcr_i, fcr_trig_i (FCR[7:6]),
//               fifo_clr_i (FCR[1] pulse), host (uart_rx_if.slave: RBR pop,
//               LSR read, FIFO head, DR/OE/PE/FE/BI, fill level, irq)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_rx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_i,
    input  logic [15:0] baud_div_i,
    input  logic [7:0]  lcr_i,
    input  logic [1:0]  fcr_trig_i,
    input  logic        fifo_clr_i,
    uart_rx_if.slave    host
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // ---------------------------------------------------------------- sync
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_prev;
    logic                   w_rx;
    logic                   w_fall;

    assign w_rx   = r_sync[SYNC_STAGES-1];
    assign w_fall = r_rx_prev & ~w_rx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync    <= '1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], rx_i};
            r_rx_prev <= w_rx;
        end
    end

    // ---------------------------------------------------------------- tick
    // The divisor is captured at each wrap so a new value only takes effect
    // at the next wrap; a captured zero disables ticks and freezes the FSM.
    logic [15:0] r_div;
    logic [15:0] r_div_cnt;
    logic        w_en;
    logic        w_tick;

    assign w_en   = (r_div != 16'd0);
    assign w_tick = w_en && (r_div_cnt == r_div - 16'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div     <= 16'd0;
            r_div_cnt <= 16'd0;
        end else if (!w_en || w_tick) begin
            r_div     <= baud_div_i;
            r_div_cnt <= 16'd0;
        end else begin
            r_div_cnt <= r_div_cnt + 16'd1;
        end
    end

    // ---------------------------------------------------------------- FSM
    rx_state_e   r_state, w_state_nxt;
    logic [3:0]  r_smp, w_smp_nxt;
    logic [2:0]  r_bitcnt, w_bitcnt_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic        r_perr, w_perr_nxt;
    logic        r_zero, w_zero_nxt;      // every data/parity bit so far was 0
    logic [1:0]  r_wls, w_wls_nxt;
    logic        r_pen, w_pen_nxt;
    logic        r_eps, w_eps_nxt;
    logic        r_stick, w_stick_nxt;
    logic        w_push;
    logic        w_fe_set;
    logic        w_bi_set;
    logic        w_pe_set;
    logic        w_mid;
    logic        w_lcr_unused;

    // LCR[2] (stop bits) and LCR[7:6] do not affect reception
    assign w_lcr_unused = ^{lcr_i[7:6], lcr_i[2]};

    // After the start-bit mid-point the sample counter restarts at 0, so
    // every later mid-bit falls on the tick where it reads 15.
    assign w_mid = (r_smp == 4'd15);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= RX_IDLE;
            r_smp    <= 4'd0;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'd0;
            r_perr   <= 1'b0;
            r_zero   <= 1'b0;
            r_wls    <= 2'd0;
            r_pen    <= 1'b0;
            r_eps    <= 1'b0;
            r_stick  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_smp    <= w_smp_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_perr   <= w_perr_nxt;
            r_zero   <= w_zero_nxt;
            r_wls    <= w_wls_nxt;
            r_pen    <= w_pen_nxt;
            r_eps    <= w_eps_nxt;
            r_stick  <= w_stick_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_smp_nxt    = r_smp;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_perr_nxt   = r_perr;
        w_zero_nxt   = r_zero;
        w_wls_nxt    = r_wls;
        w_pen_nxt    = r_pen;
        w_eps_nxt    = r_eps;
        w_stick_nxt  = r_stick;
        w_push       = 1'b0;
        w_fe_set     = 1'b0;
        w_bi_set     = 1'b0;
        w_pe_set     = 1'b0;

        if (w_en) begin
            case (r_state)
                RX_IDLE: begin
                    if (w_fall) begin
                        w_state_nxt  = RX_START;
                        w_smp_nxt    = 4'd0;
                        w_bitcnt_nxt = 3'd0;
                        w_shift_nxt  = 8'd0;
                        w_perr_nxt   = 1'b0;
                        w_zero_nxt   = 1'b1;
                        w_wls_nxt    = lcr_i[LCR_WLS +: 2];
                        w_pen_nxt    = lcr_i[LCR_PEN];
                        w_eps_nxt    = lcr_i[LCR_EPS];
                        w_stick_nxt  = lcr_i[LCR_STICK];
                    end
                end
                RX_START: begin
                    if (w_tick) begin
                        w_smp_nxt = r_smp + 4'd1;
                        if (r_smp == 4'd7) begin
                            if (!w_rx) begin
                                w_state_nxt = RX_DATA;
                                w_smp_nxt   = 4'd0;
                            end else begin
                                w_state_nxt = RX_IDLE;
                            end
                        end
                    end
                end
                RX_DATA: begin
                    if (w_tick) begin
                        w_smp_nxt = r_smp + 4'd1;
                        if (w_mid) begin
                            w_shift_nxt[r_bitcnt] = w_rx;
                            w_zero_nxt            = r_zero & ~w_rx;
                            // last index is 4 + WLS, i.e. {1, WLS}
                            if (r_bitcnt == {1'b1, r_wls}) begin
                                w_bitcnt_nxt = 3'd0;
                                w_state_nxt  = r_pen ? RX_PARITY : RX_STOP;
                            end else begin
                                w_bitcnt_nxt = r_bitcnt + 3'd1;
                            end
                        end
                    end
                end
                RX_PARITY: begin
                    if (w_tick) begin
                        w_smp_nxt = r_smp + 4'd1;
                        if (w_mid) begin
                            w_perr_nxt  = (w_rx != exp_parity(r_shift, r_eps, r_stick));
                            w_zero_nxt  = r_zero & ~w_rx;
                            w_state_nxt = RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (w_tick) begin
                        w_smp_nxt = r_smp + 4'd1;
                        if (w_mid) begin
                            // A break leaves the shift register all zero, so
                            // the pushed character is 0x00 without special-casing.
                            w_push      = 1'b1;
                            w_fe_set    = ~w_rx;
                            w_bi_set    = r_zero & ~w_rx;
                            w_pe_set    = r_perr;
                            w_state_nxt = w_rx ? RX_IDLE : RX_BRK_WAIT;
                        end
                    end
                end
                RX_BRK_WAIT: begin
                    if (w_rx)
                        w_state_nxt = RX_IDLE;
                end
                default: begin
                    w_state_nxt = RX_IDLE;
                end
            endcase
        end

        // Flush aborts the frame in progress, including a push in this cycle
        if (fifo_clr_i) begin
            w_state_nxt = RX_IDLE;
            w_push      = 1'b0;
            w_fe_set    = 1'b0;
            w_bi_set    = 1'b0;
            w_pe_set    = 1'b0;
        end
    end

    // ---------------------------------------------------------------- FIFO
    logic          w_full;
    logic          w_empty;
    logic          w_oe_set;
    logic [CW-1:0] w_trig_lvl;

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (fifo_clr_i),
        .i_push  (w_push),
        .i_wdata (r_shift),
        .i_pop   (host.fifo_pop_i),
        .o_rdata (host.rdata_o),
        .o_count (host.fifo_count_o),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_oe_set          = w_push & w_full & ~host.fifo_pop_i;
    assign w_trig_lvl        = CW'(trig_level(fcr_trig_i));
    assign host.data_ready_o = ~w_empty;
    assign host.irq_rx_o     = (host.fifo_count_o >= w_trig_lvl);

    // ---------------------------------------------------------------- LSR
    // Sticky error bits: a set in the same cycle as an LSR read wins.
    logic r_oe, r_pe, r_fe, r_bi;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_oe <= 1'b0;
            r_pe <= 1'b0;
            r_fe <= 1'b0;
            r_bi <= 1'b0;
        end else begin
            r_oe <= w_oe_set | (r_oe & ~host.lsr_rd_i);
            r_pe <= w_pe_set | (r_pe & ~host.lsr_rd_i);
            r_fe <= w_fe_set | (r_fe & ~host.lsr_rd_i);
            r_bi <= w_bi_set | (r_bi & ~host.lsr_rd_i);
        end
    end

    assign host.overrun_o     = r_oe;
    assign host.parity_err_o  = r_pe;
    assign host.framing_err_o = r_fe;
    assign host.break_o       = r_bi;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. Drives serial frames built
//               from the character format rules and compares received data
//               and LSR status against values computed in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_i;
    logic [15:0] baud_div;
    logic [7:0]  lcr;
    logic [1:0]  fcr_trig;
    logic        fifo_clr;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          dr_latency = 155;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    uart_rx_if #(.FIFO_DEPTH(16)) bus();

    uart_rx #(
        .FIFO_DEPTH  (16),
        .SYNC_STAGES (2)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (rx_i),
        .baud_div_i (baud_div),
        .lcr_i      (lcr),
        .fcr_trig_i (fcr_trig),
        .fifo_clr_i (fifo_clr),
        .host       (bus.slave)
    );

    // ------------------------------------------------------------ model
    function automatic logic [7:0] lcr_code(int nbits, logic pen, logic eps, logic stick);
        return 8'(nbits - 5) | ({7'd0, pen} << 3) | ({7'd0, eps} << 4) | ({7'd0, stick} << 5);
    endfunction

    // Character as seen by the host: only the low nbits survive
    function automatic logic [7:0] ref_char(logic [7:0] d, int nbits);
        return 8'(int'(d) % (1 << nbits));
    endfunction

    // Parity bit that makes a frame correct
    function automatic logic ref_parity(logic [7:0] d, int nbits, logic eps, logic stick);
        int ones = 0;
        for (int i = 0; i < nbits; i++) ones += (int'(d) >> i) % 2;
        if (stick) return !eps;
        if (eps)   return (ones % 2) == 1;
        return (ones % 2) == 0;
    endfunction

    // ------------------------------------------------------------ drivers
    task automatic send_bit(logic b);
        rx_i = b;
        repeat (16 * int'(baud_div)) @(negedge clk);
    endtask

    task automatic send_frame(logic [7:0] d, int nbits, logic pen, logic pbit, logic stopb);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i]);
        if (pen) send_bit(pbit);
        send_bit(stopb);
        rx_i = 1'b1;
    endtask

    task automatic pulse_pop();
        bus.fifo_pop_i = 1'b1;
        @(negedge clk);
        bus.fifo_pop_i = 1'b0;
    endtask

    task automatic pulse_lsr();
        bus.lsr_rd_i = 1'b1;
        @(negedge clk);
        bus.lsr_rd_i = 1'b0;
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        rst = 1'b0; rx_i = 1'b1; baud_div = 16'd1; lcr = 8'h03;
        fcr_trig = 2'b00; fifo_clr = 1'b0;
        bus.fifo_pop_i = 1'b0; bus.lsr_rd_i = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.data_ready_o, bus.overrun_o, bus.parity_err_o, bus.framing_err_o,
             bus.break_o, bus.irq_rx_o} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b required 000000",
                {bus.data_ready_o, bus.overrun_o, bus.parity_err_o,
                 bus.framing_err_o, bus.break_o, bus.irq_rx_o});
        end
        n_checks++;
        if (bus.rdata_o !== 8'h00 || bus.fifo_count_o !== 5'd0) begin
            n_fail++; $display("FAIL reset_fifo: rdata %h count %0d required 00 / 0",
                bus.rdata_o, bus.fifo_count_o);
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus.data_ready_o !== 1'b0 || bus.fifo_count_o !== 5'd0) begin
            n_fail++; $display("FAIL reset_idle: dr %b count %0d required 0 / 0",
                bus.data_ready_o, bus.fifo_count_o);
        end
    endtask

    task automatic test_basic_8n1();
        int n = 0;
        lcr = lcr_code(8, 0, 0, 0);
        fork
            send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
            begin
                while (bus.data_ready_o !== 1'b1 && n < 400) begin
                    @(negedge clk); n++;
                end
            end
        join
        n_checks++;
        if (n < 145 || n > 170) begin
            n_fail++; $display("FAIL basic_latency: DR after %0d clk required 145..170", n);
        end else begin
            dr_latency = n;
        end
        n_checks++;
        if (bus.rdata_o !== 8'hA5) begin
            n_fail++; $display("FAIL basic_rdata: got %h required a5", bus.rdata_o);
        end
        n_checks++;
        if ({bus.overrun_o, bus.parity_err_o, bus.framing_err_o, bus.break_o} !== 4'b0
            || bus.fifo_count_o !== 5'd1) begin
            n_fail++; $display("FAIL basic_status: errs %b count %0d required 0000 / 1",
                {bus.overrun_o, bus.parity_err_o, bus.framing_err_o, bus.break_o},
                bus.fifo_count_o);
        end
        pulse_pop();
        n_checks++;
        if (bus.data_ready_o !== 1'b0 || bus.rdata_o !== 8'h00) begin
            n_fail++; $display("FAIL basic_pop: dr %b rdata %h required 0 / 00",
                bus.data_ready_o, bus.rdata_o);
        end
    endtask

    task automatic test_parity();
        logic p;
        lcr = lcr_code(7, 1, 1, 0);
        p = ref_parity(8'h35, 7, 1'b1, 1'b0);
        send_frame(8'h35, 7, 1'b1, ~p, 1'b1);
        n_checks++;
        if (bus.rdata_o !== 8'h35 || bus.parity_err_o !== 1'b1) begin
            n_fail++; $display("FAIL parity_bad: rdata %h pe %b required 35 / 1",
                bus.rdata_o, bus.parity_err_o);
        end
        pulse_lsr();
        n_checks++;
        if (bus.parity_err_o !== 1'b0) begin
            n_fail++; $display("FAIL parity_clear: pe %b required 0", bus.parity_err_o);
        end
        pulse_pop();
        send_frame(8'h35, 7, 1'b1, p, 1'b1);
        n_checks++;
        if (bus.rdata_o !== 8'h35 || bus.parity_err_o !== 1'b0) begin
            n_fail++; $display("FAIL parity_good: rdata %h pe %b required 35 / 0",
                bus.rdata_o, bus.parity_err_o);
        end
        pulse_pop();
    endtask

    task automatic test_framing_break();
        lcr = lcr_code(8, 0, 0, 0);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        n_checks++;
        if (bus.rdata_o !== 8'h55 || bus.framing_err_o !== 1'b1 || bus.break_o !== 1'b0) begin
            n_fail++; $display("FAIL framing: rdata %h fe %b bi %b required 55 / 1 / 0",
                bus.rdata_o, bus.framing_err_o, bus.break_o);
        end
        pulse_lsr();
        pulse_pop();
        rx_i = 1'b0;
        repeat (20 * 16) @(negedge clk);
        n_checks++;
        if (bus.fifo_count_o !== 5'd1 || bus.rdata_o !== 8'h00
            || bus.break_o !== 1'b1 || bus.framing_err_o !== 1'b1) begin
            n_fail++; $display("FAIL break: count %0d rdata %h bi %b fe %b required 1 / 00 / 1 / 1",
                bus.fifo_count_o, bus.rdata_o, bus.break_o, bus.framing_err_o);
        end
        rx_i = 1'b1;
        repeat (40) @(negedge clk);
        n_checks++;
        if (bus.fifo_count_o !== 5'd1) begin
            n_fail++; $display("FAIL break_release: count %0d required 1", bus.fifo_count_o);
        end
        pulse_lsr();
        pulse_pop();
        n_checks++;
        if (bus.break_o !== 1'b0 || bus.framing_err_o !== 1'b0) begin
            n_fail++; $display("FAIL break_clear: bi %b fe %b required 0 / 0",
                bus.break_o, bus.framing_err_o);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        lcr = lcr_code(8, 0, 0, 0);
        exp_q.delete();
        for (int i = 0; i < 17; i++) begin
            d = 8'($urandom);
            send_frame(d, 8, 1'b0, 1'b0, 1'b1);
            if (i < 16) exp_q.push_back(d);
        end
        n_checks++;
        if (bus.fifo_count_o !== 5'd16 || bus.overrun_o !== 1'b1) begin
            n_fail++; $display("FAIL overflow: count %0d oe %b required 16 / 1",
                bus.fifo_count_o, bus.overrun_o);
        end
        for (int i = 0; i < 16; i++) begin
            d = exp_q.pop_front();
            n_checks++;
            if (bus.rdata_o !== d) begin
                n_fail++; $display("FAIL overflow_order[%0d]: got %h required %h", i, bus.rdata_o, d);
            end
            pulse_pop();
        end
        pulse_lsr();
        // refill, then push the 17th in the very cycle of a pop
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            send_frame(d, 8, 1'b0, 1'b0, 1'b1);
            exp_q.push_back(d);
        end
        d = 8'($urandom);
        fork
            send_frame(d, 8, 1'b0, 1'b0, 1'b1);
            begin
                repeat (dr_latency - 1) @(negedge clk);
                bus.fifo_pop_i = 1'b1;
                @(negedge clk);
                bus.fifo_pop_i = 1'b0;
            end
        join
        void'(exp_q.pop_front());
        exp_q.push_back(d);
        n_checks++;
        if (bus.fifo_count_o !== 5'd16 || bus.overrun_o !== 1'b0) begin
            n_fail++; $display("FAIL full_push_pop: count %0d oe %b required 16 / 0",
                bus.fifo_count_o, bus.overrun_o);
        end
        for (int i = 0; i < 16; i++) begin
            d = exp_q.pop_front();
            n_checks++;
            if (bus.rdata_o !== d) begin
                n_fail++; $display("FAIL full_push_pop_order[%0d]: got %h required %h", i, bus.rdata_o, d);
            end
            pulse_pop();
        end
    endtask

    task automatic test_glitch_irq();
        lcr = lcr_code(8, 0, 0, 0);
        fcr_trig = 2'b01;
        rx_i = 1'b0;
        repeat (3) @(negedge clk);
        rx_i = 1'b1;
        repeat (300) @(negedge clk);
        n_checks++;
        if (bus.fifo_count_o !== 5'd0 || bus.framing_err_o !== 1'b0) begin
            n_fail++; $display("FAIL glitch: count %0d fe %b required 0 / 0",
                bus.fifo_count_o, bus.framing_err_o);
        end
        for (int i = 0; i < 4; i++) begin
            send_frame(8'(8'h10 + i), 8, 1'b0, 1'b0, 1'b1);
            n_checks++;
            if (bus.irq_rx_o !== (i == 3)) begin
                n_fail++; $display("FAIL irq_trig4[%0d]: irq %b required %b", i, bus.irq_rx_o, i == 3);
            end
        end
        fcr_trig = 2'b10;
        @(negedge clk);
        n_checks++;
        if (bus.irq_rx_o !== 1'b0) begin
            n_fail++; $display("FAIL irq_trig8: irq %b required 0", bus.irq_rx_o);
        end
        fcr_trig = 2'b00;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.rdata_o !== 8'(8'h10 + i)) begin
                n_fail++; $display("FAIL glitch_data[%0d]: got %h required %h", i, bus.rdata_o, 8'(8'h10 + i));
            end
            pulse_pop();
        end
    endtask

    task automatic test_reset_clr();
        lcr = lcr_code(8, 0, 0, 0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        rst = 1'b0;
        rx_i = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.fifo_count_o !== 5'd0 || bus.data_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_midframe: count %0d dr %b required 0 / 0",
                bus.fifo_count_o, bus.data_ready_o);
        end
        rst = 1'b1;
        repeat (200) @(negedge clk);
        n_checks++;
        if (bus.fifo_count_o !== 5'd0 || bus.framing_err_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_after: count %0d fe %b required 0 / 0",
                bus.fifo_count_o, bus.framing_err_o);
        end
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
        send_frame(8'h33, 8, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        fifo_clr = 1'b1;
        @(negedge clk);
        fifo_clr = 1'b0;
        n_checks++;
        if (bus.fifo_count_o !== 5'd0 || bus.data_ready_o !== 1'b0
            || bus.rdata_o !== 8'h00 || bus.framing_err_o !== 1'b1) begin
            n_fail++; $display("FAIL fifo_clr: count %0d dr %b rdata %h fe %b required 0 / 0 / 00 / 1",
                bus.fifo_count_o, bus.data_ready_o, bus.rdata_o, bus.framing_err_o);
        end
        pulse_lsr();
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (bus.rdata_o !== 8'h5A || bus.fifo_count_o !== 5'd1 || bus.framing_err_o !== 1'b0) begin
            n_fail++; $display("FAIL clr_next: rdata %h count %0d fe %b required 5a / 1 / 0",
                bus.rdata_o, bus.fifo_count_o, bus.framing_err_o);
        end
        pulse_pop();
    endtask

    task automatic test_random_formats();
        logic [7:0] d, e;
        logic pen, eps, stick, bad, p;
        int nbits;
        for (int k = 0; k < 12; k++) begin
            baud_div = 16'($urandom_range(1, 3));
            nbits = $urandom_range(5, 8);
            pen = 1'($urandom); eps = 1'($urandom); stick = 1'($urandom);
            bad = pen & 1'($urandom);
            d = 8'($urandom);
            lcr = lcr_code(nbits, pen, eps, stick);
            repeat (20) @(negedge clk);
            p = ref_parity(d, nbits, eps, stick);
            send_frame(d, nbits, pen, p ^ bad, 1'b1);
            e = ref_char(d, nbits);
            n_checks++;
            if (bus.rdata_o !== e || bus.parity_err_o !== bad
                || bus.framing_err_o !== 1'b0 || bus.fifo_count_o !== 5'd1) begin
                n_fail++; $display("FAIL random[%0d] lcr %h div %0d: rdata %h pe %b fe %b count %0d required %h / %b / 0 / 1",
                    k, lcr, baud_div, bus.rdata_o, bus.parity_err_o, bus.framing_err_o,
                    bus.fifo_count_o, e, bad);
            end
            pulse_lsr();
            pulse_pop();
        end
        baud_div = 16'd1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        lcr = lcr_code(8, 0, 0, 0);
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            exp_q.push_back(d);
            send_frame(d, 8, 1'b0, 1'b0, 1'b1);
        end
        n_checks++;
        if (bus.fifo_count_o !== 5'd6) begin
            n_fail++; $display("FAIL b2b_count: got %0d required 6", bus.fifo_count_o);
        end
        for (int i = 0; i < 6; i++) begin
            d = exp_q.pop_front();
            n_checks++;
            if (bus.rdata_o !== d) begin
                n_fail++; $display("FAIL b2b_data[%0d]: got %h required %h", i, bus.rdata_o, d);
            end
            pulse_pop();
        end
    endtask

    initial begin
        test_reset();
        test_basic_8n1();
        test_parity();
        test_framing_break();
        test_overflow();
        test_glitch_irq();
        test_reset_clr();
        test_random_formats();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
